// File: rtl/usb_bluejay_pkg.sv
// Shared types and default sizing for the USB FIFO to Bluejay SLM bridge.
package usb_bluejay_pkg;

    localparam int DATA_W_DEF          = 32;
    localparam int WORDS_PER_LINE_DEF  = 40;    // 1280 px x 1 bit / 32
    localparam int LINES_PER_FRAME_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_READY
    } state_e;

endpackage

// File: rtl/usb_bluejay_line_frame_cnt.sv
// Word/line position counters and the registered end-of-line / end-of-frame
// pulses, aligned with the cycle in which data_o shows the transferred word.
module usb_bluejay_line_frame_cnt
    import usb_bluejay_pkg::*;
#(
    parameter int WORDS_PER_LINE  = WORDS_PER_LINE_DEF,
    parameter int LINES_PER_FRAME = LINES_PER_FRAME_DEF
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic xfer_i,
    output logic line_rdy_o,
    output logic frame_rdy_o
);

    localparam int WCW = (WORDS_PER_LINE  > 1) ? $clog2(WORDS_PER_LINE)  : 1;
    localparam int LCW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;

    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [LCW-1:0] line_cnt_q, line_cnt_d;
    logic           line_rdy_q, line_rdy_d;
    logic           frame_rdy_q, frame_rdy_d;
    logic           last_word, last_line;

    assign last_word = (word_cnt_q == WCW'(WORDS_PER_LINE - 1));
    assign last_line = (line_cnt_q == LCW'(LINES_PER_FRAME - 1));

    // Advance position on each transfer; pulses last exactly one cycle.
    always_comb begin
        word_cnt_d  = word_cnt_q;
        line_cnt_d  = line_cnt_q;
        line_rdy_d  = 1'b0;
        frame_rdy_d = 1'b0;
        if (xfer_i) begin
            if (last_word) begin
                word_cnt_d = '0;
                line_rdy_d = 1'b1;
                if (last_line) begin
                    line_cnt_d  = '0;
                    frame_rdy_d = 1'b1;
                end else begin
                    line_cnt_d = line_cnt_q + 1'b1;
                end
            end else begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end
    end

    // Counter and pulse registers; reset discards any partial line/frame.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            word_cnt_q  <= '0;
            line_cnt_q  <= '0;
            line_rdy_q  <= 1'b0;
            frame_rdy_q <= 1'b0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            line_cnt_q  <= line_cnt_d;
            line_rdy_q  <= line_rdy_d;
            frame_rdy_q <= frame_rdy_d;
        end
    end

    assign line_rdy_o  = line_rdy_q;
    assign frame_rdy_o = frame_rdy_q;

endmodule

// File: rtl/usb_bluejay_if.sv
// USB FIFO to Bluejay SLM bridge: primes the FIFO bus, forwards one word per
// downstream request and flags line/frame boundaries.
module usb_bluejay_if
    import usb_bluejay_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEF,
    parameter int WORDS_PER_LINE  = WORDS_PER_LINE_DEF,
    parameter int LINES_PER_FRAME = LINES_PER_FRAME_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              fifo_empty_i,
    input  logic              get_next_word_i,
    output logic              fifo_output_enable_o,
    output logic              get_next_word_o,
    output logic              reset_o,
    output logic              clk_o,
    output logic [DATA_W-1:0] data_o,
    output logic              next_line_rdy_o,
    output logic              next_frame_rdy_o,
    output logic              fifo_empty_o
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ready;

    assign clk_o   = clk_i;
    assign reset_o = reset_i;

    // Strobe and empty flag are gated by reset so they are quiet before the
    // state register has been cleared.
    assign ready                = reset_i & (state_q == ST_READY);
    assign get_next_word_o      = ready & get_next_word_i & ~fifo_empty_i;
    assign fifo_empty_o         = ~(ready & ~fifo_empty_i);
    assign fifo_output_enable_o = (state_q != ST_IDLE);

    // Next state: PRIME is a single bus-turnaround cycle with OE up, no read.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty_i) state_d = ST_PRIME;
            ST_PRIME: state_d = ST_READY;
            ST_READY: if (fifo_empty_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Capture the FIFO word on a read strobe, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (get_next_word_o) data_d = data_i;
    end

    // State and data registers.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign data_o = data_q;

    usb_bluejay_line_frame_cnt #(
        .WORDS_PER_LINE  (WORDS_PER_LINE),
        .LINES_PER_FRAME (LINES_PER_FRAME)
    ) u_cnt (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .xfer_i      (get_next_word_o),
        .line_rdy_o  (next_line_rdy_o),
        .frame_rdy_o (next_frame_rdy_o)
    );

endmodule

// File: tb/tb_usb_bluejay_if.sv
// Randomized bench for usb_bluejay_if against a behavioural model that tracks
// bus availability by age and line/frame boundaries by total word count.
module tb_usb_bluejay_if;

    localparam int WPL = 4;
    localparam int LPF = 2;

    logic        clk = 1'b0;
    logic        rst, empty, req;
    logic [31:0] din;
    logic        oe, gnw, rst_o, clk_o, line_o, frame_o, fe;
    logic [31:0] dout;

    always #5 clk = ~clk;

    usb_bluejay_if #(
        .DATA_W          (32),
        .WORDS_PER_LINE  (WPL),
        .LINES_PER_FRAME (LPF)
    ) dut (
        .clk_i                (clk),
        .reset_i              (rst),
        .data_i               (din),
        .fifo_empty_i         (empty),
        .get_next_word_i      (req),
        .fifo_output_enable_o (oe),
        .get_next_word_o      (gnw),
        .reset_o              (rst_o),
        .clk_o                (clk_o),
        .data_o               (dout),
        .next_line_rdy_o      (line_o),
        .next_frame_rdy_o     (frame_o),
        .fifo_empty_o         (fe)
    );

    int total = 0;
    int bad   = 0;

    // Model: up = cycles since OE went high (-1 = bus released);
    // reads allowed once up >= 1. nwords = words delivered since reset.
    int          up;
    longint      nwords;
    logic [31:0] m_data;
    logic        m_line, m_frame;
    int          line_seen, frame_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, check outputs mid-cycle, advance model at edge.
    task automatic cyc(input logic r, input logic e, input logic q, input logic [31:0] d);
        logic can_read, xfer;
        rst = r; empty = e; req = q; din = d;
        #2;
        can_read = r && (up >= 1);
        chk("oe",    {31'd0, oe},      {31'd0, up >= 0});
        chk("strobe",{31'd0, gnw},     {31'd0, can_read && q && !e});
        chk("empty", {31'd0, fe},      {31'd0, !(can_read && !e)});
        chk("data",  dout,             m_data);
        chk("line",  {31'd0, line_o},  {31'd0, m_line});
        chk("frame", {31'd0, frame_o}, {31'd0, m_frame});
        chk("clk_o", {31'd0, clk_o},   {31'd0, clk});
        chk("rst_o", {31'd0, rst_o},   {31'd0, r});
        if (line_o === 1'b1)  line_seen++;
        if (frame_o === 1'b1) frame_seen++;
        @(posedge clk);
        if (!r) begin
            up = -1; nwords = 0; m_data = '0; m_line = 1'b0; m_frame = 1'b0;
        end else begin
            xfer    = (up >= 1) && q && !e;
            m_line  = 1'b0;
            m_frame = 1'b0;
            if (xfer) begin
                m_data  = d;
                nwords++;
                m_line  = (nwords % WPL) == 0;
                m_frame = (nwords % (WPL * LPF)) == 0;
            end
            if (up < 0)       up = e ? -1 : 0;
            else if (up == 0) up = 1;
            else              up = e ? -1 : up + 1;
        end
        #1;
    endtask

    initial begin
        up = -1; nwords = 0; m_data = '0; m_line = 1'b0; m_frame = 1'b0;
        line_seen = 0; frame_seen = 0;
        rst = 1'b0; empty = 1'b0; req = 1'b1; din = '0;
        @(posedge clk); #1;

        // Reset held with FIFO non-empty and a request pending.
        repeat (3) cyc(1'b0, 1'b0, 1'b1, $urandom);

        // Prime: IDLE, PRIME, then first read of 0xDEADBEEF.
        cyc(1'b1, 1'b0, 1'b1, $urandom);
        cyc(1'b1, 1'b0, 1'b1, $urandom);
        cyc(1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
        cyc(1'b1, 1'b0, 1'b0, $urandom);
        chk("deadbeef_hold", dout, 32'hDEADBEEF);

        // Complete 8 words = 2 lines = 1 frame.
        line_seen = 0; frame_seen = 0;
        repeat (7) cyc(1'b1, 1'b0, 1'b1, $urandom);
        cyc(1'b1, 1'b0, 1'b0, $urandom);
        chk("n_line_pulses",  line_seen,  2);
        chk("n_frame_pulses", frame_seen, 1);

        // Empty mid-stream: strobe suppressed, re-prime, count continues.
        cyc(1'b1, 1'b0, 1'b1, $urandom);
        cyc(1'b1, 1'b1, 1'b1, $urandom);
        chk("empty_oe_drop", {31'd0, oe}, 32'd0);
        cyc(1'b1, 1'b0, 1'b1, $urandom);
        cyc(1'b1, 1'b0, 1'b1, $urandom);
        cyc(1'b1, 1'b0, 1'b1, $urandom);

        // Reset two words into a line; next four words close line 0.
        cyc(1'b0, 1'b0, 1'b1, $urandom);
        cyc(1'b1, 1'b0, 1'b1, $urandom);
        cyc(1'b1, 1'b0, 1'b1, $urandom);
        line_seen = 0;
        repeat (4) cyc(1'b1, 1'b0, 1'b1, $urandom);
        cyc(1'b1, 1'b0, 1'b0, $urandom);
        chk("reset_line_restart", line_seen, 1);

        // Random traffic with occasional empties and resets.
        repeat (3000) begin
            cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 3) != 0), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
